// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter and its shifter datapath.
package shift_arbiter_pkg;

   // Direction encoding carried on req_dir.
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // Ceiling log2, used to size shift-amount and requester-id fields.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request and result bus between the client pipelines and the shift arbiter.
interface shift_arbiter_if #(
   parameter int width = 8,
   parameter int nreq  = 4
);
   localparam int SW  = shift_arbiter_pkg::clog2(width);
   localparam int IDW = shift_arbiter_pkg::clog2(nreq);

   logic [nreq-1:0]       req_valid;
   logic [nreq-1:0]       req_ready;
   logic [nreq*width-1:0] req_bits;
   logic [nreq*SW-1:0]    req_shift;
   logic [nreq-1:0]       req_dir;
   logic                  out_valid;
   logic                  out_ready;
   logic [width-1:0]      out_bits;
   logic [IDW-1:0]        out_id;

   modport master (
      output req_valid, req_bits, req_shift, req_dir, out_ready,
      input  req_ready, out_valid, out_bits, out_id
   );

   modport slave (
      input  req_valid, req_bits, req_shift, req_dir, out_ready,
      output req_ready, out_valid, out_bits, out_id
   );
endinterface

// File: rtl/shift_arbiter_shift.sv
// Combinational bidirectional logical shifter with zero result for
// out-of-range shift amounts (only reachable for non-power-of-2 widths).
module bidir_shift_gen
   import shift_arbiter_pkg::*;
#(
   parameter int width = 8,
   localparam int SW = clog2(width)
) (
   input  logic [width-1:0] iBits,
   input  logic [SW-1:0]    shift,
   input  logic             dir,
   output logic [width-1:0] oBits
);

   // Zero-filled shift; amounts at or beyond the width clear the result.
   always_comb begin
      oBits = '0;
      if ({1'b0, shift} >= (SW+1)'(width)) begin
         oBits = '0;
      end else if (dir == DIR_LEFT) begin
         oBits = iBits << shift;
      end else begin
         oBits = iBits >> shift;
      end
   end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter among nreq requesters, with a
// single registered result stage returning the result and requester id.
module shift_arbiter
   import shift_arbiter_pkg::*;
#(
   parameter int width = 8,
   parameter int nreq  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   shift_arbiter_if.slave  bus
);

   localparam int SW  = clog2(width);
   localparam int IDW = clog2(nreq);

   logic             out_valid_q, out_valid_d;
   logic [width-1:0] out_bits_q, out_bits_d;
   logic [IDW-1:0]   out_id_q, out_id_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

   logic             gnt_vld;
   logic [IDW-1:0]   gnt_id;
   logic             can_load;
   logic             fire;
   logic [width-1:0] sel_bits;
   logic [SW-1:0]    sel_shift;
   logic             sel_dir;
   logic [width-1:0] shifted;

   // Round-robin scan of req_valid starting at rr_ptr, wrapping modulo nreq.
   always_comb begin
      logic [IDW:0] idx;
      gnt_vld = 1'b0;
      gnt_id  = '0;
      idx     = '0;
      for (int k = 0; k < nreq; k++) begin
         idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (idx >= (IDW+1)'(nreq)) idx = idx - (IDW+1)'(nreq);
         for (int i = 0; i < nreq; i++) begin
            if (!gnt_vld && (idx == (IDW+1)'(i)) && bus.req_valid[i]) begin
               gnt_vld = 1'b1;
               gnt_id  = IDW'(i);
            end
         end
      end
   end

   // Route the granted requester's operands into the shared shifter.
   always_comb begin
      sel_bits  = '0;
      sel_shift = '0;
      sel_dir   = DIR_LEFT;
      for (int i = 0; i < nreq; i++) begin
         if (gnt_id == IDW'(i)) begin
            sel_bits  = bus.req_bits[i*width +: width];
            sel_shift = bus.req_shift[i*SW +: SW];
            sel_dir   = bus.req_dir[i];
         end
      end
   end

   bidir_shift_gen #(.width(width)) u_shift (
      .iBits (sel_bits),
      .shift (sel_shift),
      .dir   (sel_dir),
      .oBits (shifted)
   );

   // Accept only into a free (or draining) output stage; nothing during reset.
   always_comb begin
      can_load      = !out_valid_q || bus.out_ready;
      fire          = gnt_vld && can_load && rst_n;
      bus.req_ready = '0;
      for (int i = 0; i < nreq; i++) begin
         if (gnt_vld && (gnt_id == IDW'(i))) bus.req_ready[i] = can_load && rst_n;
      end
   end

   // Next state: load on transfer, drain on accept, otherwise hold.
   always_comb begin
      out_valid_d = fire || (out_valid_q && !bus.out_ready);
      out_bits_d  = out_bits_q;
      out_id_d    = out_id_q;
      rr_ptr_d    = rr_ptr_q;
      if (fire) begin
         out_bits_d = shifted;
         out_id_d   = gnt_id;
         rr_ptr_d   = (gnt_id == IDW'(nreq - 1)) ? '0 : gnt_id + 1'b1;
      end
   end

   // Output register and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_bits_q  <= '0;
         out_id_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_bits_q  <= out_bits_d;
         out_id_q    <= out_id_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_bits  = out_bits_q;
   assign bus.out_id    = out_id_q;

endmodule
